// File: rtl/cva6_ldbuf_pkg.sv
// Shared types and constants for the CVA6 load tag buffer and its data extractor.
// The optional non-idempotent ordering feature is selected with CVA6_LDBUF_NONIDEM_EN.
package cva6_ldbuf_pkg;

    localparam logic [1:0] LDBUF_SIZE_B = 2'd0;
    localparam logic [1:0] LDBUF_SIZE_H = 2'd1;
    localparam logic [1:0] LDBUF_SIZE_W = 2'd2;

    function automatic int ldbuf_ofs_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Field widths for the cv32a60x configuration (4 scoreboard entries, 64-bit cache data).
    localparam int LDBUF_TRANS_ID_W = 2;
    localparam int LDBUF_OFS_W      = ldbuf_ofs_w(64);

    typedef struct packed {
        logic                        valid;
        logic                        flushed;
        logic [LDBUF_TRANS_ID_W-1:0] trans_id;
        logic [LDBUF_OFS_W-1:0]      offset;
        logic [1:0]                  size;
        logic                        sign;
        logic                        nonidem;
    } ldbuf_entry_t;

endpackage

// File: rtl/cva6_ldbuf_extract.sv
// Aligns a cache word to the addressed byte and sign/zero-extends the selected
// byte, half or word to XLEN.
module cva6_ldbuf_extract
    import cva6_ldbuf_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int XLEN   = 32,
    parameter int OFS_W  = ldbuf_ofs_w(DATA_W)
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [OFS_W-1:0]  offset_i,
    input  logic [1:0]        size_i,
    input  logic              sign_i,
    output logic [XLEN-1:0]   result_o
);

    logic [DATA_W-1:0] shifted;
    logic [XLEN-1:0]   low;
    logic [XLEN-1:0]   mask;
    logic              msb;
    logic              unused_hi;

    assign shifted   = data_i >> {offset_i, 3'b000};
    assign low       = shifted[XLEN-1:0];
    assign unused_hi = ^shifted[DATA_W-1:XLEN];

    always_comb begin
        mask = XLEN'(32'hFFFF_FFFF);
        msb  = low[31];
        case (size_i)
            LDBUF_SIZE_B: begin
                mask = XLEN'(32'h0000_00FF);
                msb  = low[7];
            end
            LDBUF_SIZE_H: begin
                mask = XLEN'(32'h0000_FFFF);
                msb  = low[15];
            end
            default: begin
                mask = XLEN'(32'hFFFF_FFFF);
                msb  = low[31];
            end
        endcase
        result_o = (low & mask) | ((sign_i && msb) ? ~mask : '0);
    end

endmodule

// File: rtl/cva6_load_tag_buffer.sv
// Outstanding-load tracker between the load unit and the data cache; tags are buffer indices.
// Define CVA6_LDBUF_NONIDEM_EN to serialise loads to non-idempotent regions.
module cva6_load_tag_buffer
    import cva6_ldbuf_pkg::*;
#(
    parameter int  NR_ENTRIES = 2,
    parameter int  TRANS_ID_W = LDBUF_TRANS_ID_W,
    parameter int  XLEN       = 32,
    parameter int  DATA_W     = 64,
    localparam int OFS_W      = ldbuf_ofs_w(DATA_W),
    localparam int IDX_W      = $clog2(NR_ENTRIES)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [TRANS_ID_W-1:0] req_trans_id_i,
    input  logic [OFS_W-1:0]      req_offset_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_sign_i,
    input  logic                  req_nonidem_i,
    output logic [IDX_W-1:0]      req_tag_o,
    input  logic                  rsp_valid_i,
    input  logic [IDX_W-1:0]      rsp_tag_i,
    input  logic [DATA_W-1:0]     rsp_data_i,
    output logic                  result_valid_o,
    output logic [TRANS_ID_W-1:0] result_trans_id_o,
    output logic [XLEN-1:0]       result_data_o,
    output logic [IDX_W:0]        count_o
);

    localparam int CNT_W = IDX_W + 1;

    ldbuf_entry_t [NR_ENTRIES-1:0] entry_q, entry_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  result_valid_q, result_valid_d;
    logic [TRANS_ID_W-1:0] result_trans_id_q, result_trans_id_d;
    logic [XLEN-1:0]       result_data_q, result_data_d;

    logic [IDX_W-1:0] free_idx;
    logic             nonidem_busy;
    logic             alloc;
    logic             rsp_hit;
    ldbuf_entry_t     rsp_entry;
    logic [XLEN-1:0]  rsp_result;

    // Priority encoder: lowest-index free entry wins.
    always_comb begin
        free_idx     = '0;
        nonidem_busy = 1'b0;
        for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
            if (!entry_q[i].valid) free_idx = IDX_W'(i);
            if (entry_q[i].valid && entry_q[i].nonidem) nonidem_busy = 1'b1;
        end
    end

`ifdef CVA6_LDBUF_NONIDEM_EN
    assign req_ready_o = (count_q != CNT_W'(NR_ENTRIES)) && !nonidem_busy
                         && !(req_nonidem_i && (count_q != '0));
`else
    logic unused_nonidem;
    assign unused_nonidem = req_nonidem_i ^ nonidem_busy;
    assign req_ready_o    = (count_q != CNT_W'(NR_ENTRIES));
`endif

    assign req_tag_o = free_idx;
    assign alloc     = req_valid_i && req_ready_o;
    assign rsp_entry = entry_q[rsp_tag_i];
    assign rsp_hit   = rsp_valid_i && rsp_entry.valid;

    cva6_ldbuf_extract #(
        .DATA_W(DATA_W),
        .XLEN  (XLEN),
        .OFS_W (OFS_W)
    ) i_extract (
        .data_i  (rsp_data_i),
        .offset_i(rsp_entry.offset),
        .size_i  (rsp_entry.size),
        .sign_i  (rsp_entry.sign),
        .result_o(rsp_result)
    );

    // Free, then flush, then allocate: the allocated index is free in registered
    // state, so it never collides with the entry being released.
    always_comb begin
        entry_d           = entry_q;
        count_d           = count_q;
        result_valid_d    = 1'b0;
        result_trans_id_d = result_trans_id_q;
        result_data_d     = result_data_q;

        if (rsp_hit) begin
            entry_d[rsp_tag_i].valid = 1'b0;
            if (!rsp_entry.flushed && !flush_i) begin
                result_valid_d    = 1'b1;
                result_trans_id_d = rsp_entry.trans_id;
                result_data_d     = rsp_result;
            end
        end

        if (flush_i) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                if (entry_d[i].valid) entry_d[i].flushed = 1'b1;
            end
        end

        if (alloc) begin
            entry_d[free_idx].valid    = 1'b1;
            entry_d[free_idx].flushed  = flush_i;
            entry_d[free_idx].trans_id = req_trans_id_i;
            entry_d[free_idx].offset   = req_offset_i;
            entry_d[free_idx].size     = req_size_i;
            entry_d[free_idx].sign     = req_sign_i;
`ifdef CVA6_LDBUF_NONIDEM_EN
            entry_d[free_idx].nonidem  = req_nonidem_i;
`else
            entry_d[free_idx].nonidem  = 1'b0;
`endif
        end

        count_d = count_q + CNT_W'(alloc) - CNT_W'(rsp_hit);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entry_q           <= '0;
            count_q           <= '0;
            result_valid_q    <= 1'b0;
            result_trans_id_q <= '0;
            result_data_q     <= '0;
        end else begin
            entry_q           <= entry_d;
            count_q           <= count_d;
            result_valid_q    <= result_valid_d;
            result_trans_id_q <= result_trans_id_d;
            result_data_q     <= result_data_d;
        end
    end

    assign result_valid_o    = result_valid_q;
    assign result_trans_id_o = result_trans_id_q;
    assign result_data_o     = result_data_q;
    assign count_o           = count_q;

    a_rsp_tag_valid : assert property (@(posedge clk_i) disable iff (!rst_ni)
        rsp_valid_i |-> entry_q[rsp_tag_i].valid);

endmodule

// File: tb/tb_cva6_load_tag_buffer.sv
// Scoreboard bench for cva6_load_tag_buffer: directed loads, flushes and full/nonidem stalls.
module tb_cva6_load_tag_buffer;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_tid = '0;
    logic [2:0]  req_ofs = '0;
    logic [1:0]  req_size = '0;
    logic        req_sign = 1'b0;
    logic        req_nonidem = 1'b0;
    logic [0:0]  req_tag;
    logic        rsp_valid = 1'b0;
    logic [0:0]  rsp_tag = '0;
    logic [63:0] rsp_data = '0;
    logic        result_valid;
    logic [1:0]  result_tid;
    logic [31:0] result_data;
    logic [1:0]  count;

    always #5 clk = ~clk;

    cva6_load_tag_buffer dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .flush_i          (flush),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_trans_id_i   (req_tid),
        .req_offset_i     (req_ofs),
        .req_size_i       (req_size),
        .req_sign_i       (req_sign),
        .req_nonidem_i    (req_nonidem),
        .req_tag_o        (req_tag),
        .rsp_valid_i      (rsp_valid),
        .rsp_tag_i        (rsp_tag),
        .rsp_data_i       (rsp_data),
        .result_valid_o   (result_valid),
        .result_trans_id_o(result_tid),
        .result_data_o    (result_data),
        .count_o          (count)
    );

    typedef struct packed {
        logic [1:0]  tid;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every result pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && result_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got tid %0d data %h, expected no result",
                         result_tid, result_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result_tid", 64'(result_tid), 64'(e.tid));
                check("result_data", 64'(result_data), 64'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] tid, input logic [2:0] ofs, input logic [1:0] sz,
                           input logic sgn, input logic ni);
        req_valid   = 1'b1;
        req_tid     = tid;
        req_ofs     = ofs;
        req_size    = sz;
        req_sign    = sgn;
        req_nonidem = ni;
    endtask

    task automatic issue(input string name, input logic [1:0] tid, input logic [2:0] ofs,
                         input logic [1:0] sz, input logic sgn, input logic ni,
                         input logic [0:0] exp_tag);
        set_req(tid, ofs, sz, sgn, ni);
        #1;
        check({name, "_ready"}, 64'(req_ready), 64'd1);
        check({name, "_tag"}, 64'(req_tag), 64'(exp_tag));
        step();
        req_valid   = 1'b0;
        req_nonidem = 1'b0;
    endtask

    task automatic respond(input logic [0:0] tag, input logic [63:0] data, input logic expect_res,
                           input logic [1:0] tid, input logic [31:0] val);
        rsp_valid = 1'b1;
        rsp_tag   = tag;
        rsp_data  = data;
        if (expect_res) exp_q.push_back('{tid: tid, data: val});
        step();
        rsp_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_count", 64'(count), 64'd0);
        check("rst_tag", 64'(req_tag), 64'd0);
        check("rst_result_valid", 64'(result_valid), 64'd0);
        check("rst_result_tid", 64'(result_tid), 64'd0);
        check("rst_result_data", 64'(result_data), 64'd0);
        rst_n = 1'b1;
        step();

        // Single signed byte load
        issue("t1", 2'd2, 3'd4, SZ_B, 1'b1, 1'b0, 1'b0);
        check("t1_count", 64'(count), 64'd1);
        respond(1'b0, 64'h0000_0080_0000_0000, 1'b1, 2'd2, 32'hFFFF_FF80);
        check("t1_count_after", 64'(count), 64'd0);
        step();
        check("t1_pulse_single", 64'(result_valid), 64'd0);

        // Fill, then response and request in the same cycle
        issue("t2a", 2'd1, 3'd0, SZ_H, 1'b1, 1'b0, 1'b0);
        issue("t2b", 2'd3, 3'd0, SZ_W, 1'b0, 1'b0, 1'b1);
        check("full_ready", 64'(req_ready), 64'd0);
        check("full_count", 64'(count), 64'd2);
        set_req(2'd0, 3'd2, SZ_B, 1'b0, 1'b0);
        rsp_valid = 1'b1;
        rsp_tag   = 1'b1;
        rsp_data  = 64'h0000_0000_1234_5678;
        exp_q.push_back('{tid: 2'd3, data: 32'h1234_5678});
        #1;
        check("full_ready_same_cycle", 64'(req_ready), 64'd0);
        step();
        rsp_valid = 1'b0;
        check("freed_count", 64'(count), 64'd1);
        issue("t2c", 2'd0, 3'd2, SZ_B, 1'b0, 1'b0, 1'b1);
        respond(1'b0, 64'h0000_0000_0000_8001, 1'b1, 2'd1, 32'hFFFF_8001);
        respond(1'b1, 64'h0000_0000_00AB_0000, 1'b1, 2'd0, 32'h0000_00AB);
        check("t2_count_after", 64'(count), 64'd0);

        // Simultaneous allocate and free
        issue("af0", 2'd1, 3'd0, SZ_W, 1'b0, 1'b0, 1'b0);
        set_req(2'd2, 3'd0, SZ_W, 1'b1, 1'b0);
        rsp_valid = 1'b1;
        rsp_tag   = 1'b0;
        rsp_data  = 64'h0000_0000_CAFE_F00D;
        exp_q.push_back('{tid: 2'd1, data: 32'hCAFE_F00D});
        #1;
        check("af_tag", 64'(req_tag), 64'd1);
        step();
        rsp_valid = 1'b0;
        req_valid = 1'b0;
        check("af_count", 64'(count), 64'd1);
        check("af_free_tag", 64'(req_tag), 64'd0);
        respond(1'b1, 64'h0000_0000_8000_0000, 1'b1, 2'd2, 32'h8000_0000);
        check("af_count_after", 64'(count), 64'd0);

        // Flush with two loads outstanding
        issue("fl0", 2'd1, 3'd0, SZ_W, 1'b0, 1'b0, 1'b0);
        issue("fl1", 2'd2, 3'd0, SZ_W, 1'b0, 1'b0, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_count", 64'(count), 64'd2);
        respond(1'b0, 64'h0000_0000_1111_1111, 1'b0, 2'd0, 32'd0);
        respond(1'b1, 64'h0000_0000_2222_2222, 1'b0, 2'd0, 32'd0);
        check("fl_count_after", 64'(count), 64'd0);
        issue("fl2", 2'd3, 3'd6, SZ_H, 1'b0, 1'b0, 1'b0);
        respond(1'b0, 64'hBEEF_0000_0000_0000, 1'b1, 2'd3, 32'h0000_BEEF);

        // Response coinciding with flush, then allocation during flush
        issue("rf0", 2'd2, 3'd0, SZ_B, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        respond(1'b0, 64'h0000_0000_0000_0055, 1'b0, 2'd0, 32'd0);
        flush = 1'b0;
        check("rf_count", 64'(count), 64'd0);
        flush = 1'b1;
        issue("af_flush", 2'd1, 3'd0, SZ_B, 1'b0, 1'b0, 1'b0);
        flush = 1'b0;
        check("af_flush_count", 64'(count), 64'd1);
        respond(1'b0, 64'h0000_0000_0000_0066, 1'b0, 2'd0, 32'd0);
        check("af_flush_count_after", 64'(count), 64'd0);

        // Non-idempotent ordering
        issue("ni0", 2'd0, 3'd0, SZ_W, 1'b0, 1'b0, 1'b0);
        set_req(2'd1, 3'd0, SZ_W, 1'b0, 1'b1);
        #1;
`ifdef CVA6_LDBUF_NONIDEM_EN
        check("ni_blocked", 64'(req_ready), 64'd0);
        step();
        check("ni_still_blocked", 64'(req_ready), 64'd0);
        respond(1'b0, 64'h0000_0000_1111_2222, 1'b1, 2'd0, 32'h1111_2222);
        issue("ni1", 2'd1, 3'd0, SZ_W, 1'b0, 1'b1, 1'b0);
        set_req(2'd2, 3'd0, SZ_W, 1'b0, 1'b0);
        #1;
        check("ni_blocks_normal", 64'(req_ready), 64'd0);
        req_valid = 1'b0;
        respond(1'b0, 64'h0000_0000_3333_4444, 1'b1, 2'd1, 32'h3333_4444);
        issue("ni2", 2'd2, 3'd0, SZ_W, 1'b0, 1'b0, 1'b0);
        respond(1'b0, 64'h0000_0000_5555_6666, 1'b1, 2'd2, 32'h5555_6666);
`else
        check("ni_accept_ready", 64'(req_ready), 64'd1);
        check("ni_accept_tag", 64'(req_tag), 64'd1);
        step();
        req_valid   = 1'b0;
        req_nonidem = 1'b0;
        check("ni_count", 64'(count), 64'd2);
        respond(1'b0, 64'h0000_0000_1111_2222, 1'b1, 2'd0, 32'h1111_2222);
        respond(1'b1, 64'h0000_0000_3333_4444, 1'b1, 2'd1, 32'h3333_4444);
`endif
        check("ni_count_after", 64'(count), 64'd0);

        step();
        step();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cva6_load_tag_buffer.md
# cva6_load_tag_buffer

Tracks outstanding loads between the load unit and the data cache for the cv32a60x configuration (32-bit XLEN, 64-bit cache data, 2 load-buffer entries, 4 scoreboard entries). Each accepted load gets a cache tag (the buffer index) and the buffer stores its scoreboard transaction ID, byte offset, size and sign. When the cache returns 64-bit data for a tag, the block aligns and sign-extends it to XLEN and presents a registered writeback result. Flushed loads keep their entry until the cache answers; their data is then discarded.

## Interface
- NR_ENTRIES, 2: load-buffer depth (CVA6Cfg.NrLoadBufEntries); power of two, ≥2.
- TRANS_ID_W, 2: scoreboard transaction ID width, $clog2(NrScoreboardEntries).
- XLEN, 32: result width.
- DATA_W, 64: cache data width; offset width OFS_W = $clog2(DATA_W/8) = 3.
- IDX_W, $clog2(NR_ENTRIES): tag width (derived localparam).

Ports:
- clk_i in 1: clock.
- rst_ni in 1: reset, asynchronous, active-low.
- flush_i in 1: pipeline flush; marks all valid entries flushed.
- req_valid_i in 1: load issue request.
- req_ready_o out 1: an entry can be allocated this cycle.
- req_trans_id_i in TRANS_ID_W: scoreboard ID.
- req_offset_i in OFS_W: byte offset in the cache word.
- req_size_i in 2: 0=byte, 1=half, 2=word, 3 treated as word.
- req_sign_i in 1: sign-extend when 1, zero-extend when 0.
- req_nonidem_i in 1: address lies in a non-idempotent region.
- req_tag_o out IDX_W: index allocated on this cycle's handshake.
- rsp_valid_i in 1: cache response.
- rsp_tag_i in IDX_W: tag of the response.
- rsp_data_i in DATA_W: raw cache data.
- result_valid_o out 1: writeback pulse.
- result_trans_id_o out TRANS_ID_W: ID of the result.
- result_data_o out XLEN: aligned, extended data.
- count_o out IDX_W+1: number of valid entries.

## Operation
- Entry fields: valid, flushed, trans_id, offset, size, sign, nonidem.
- Allocation happens on req_valid_i && req_ready_o. The block takes the lowest-index free entry, and req_tag_o gives that index combinationally in the same cycle.
- req_ready_o is computed from registered state only. An entry freed in cycle N cannot be allocated until cycle N+1.
- Response on a valid entry: the entry is freed. If flushed == 0 and flush_i == 0, the result register loads {trans_id, extract(rsp_data_i)}. Otherwise no result is produced.
- Response on an invalid entry: ignored. A simulation assertion fires.
- extract: shift right by offset×8, mask to the size, then sign- or zero-extend to XLEN. Byte/half/word positions that cross the 64-bit boundary are not checked; they are illegal stimulus.
- flush_i sets flushed on every valid entry, including one being allocated in the same cycle; the request is still accepted. Flush also clears result_valid_o in the next cycle.
- Simultaneous alloc and free: count_o is unchanged and both updates apply.
- Full: req_ready_o=0 while count_o == NR_ENTRIES.

## Timing
- Result latency: rsp_valid_i in cycle N gives result_valid_o in cycle N+1, a single-cycle pulse. There is no backpressure on the result.
- Tag output: combinational from registered state.
- Reset values:
  - all entries invalid, count_o=0, req_ready_o=1;
  - result_valid_o=0, result_trans_id_o=0, result_data_o=0;
  - req_tag_o=0 (lowest free index).
- Reset mid-operation drops all outstanding entries. Late cache responses after reset are ignored as invalid-tag responses.

## Configuration
- CVA6_LDBUF_NONIDEM_EN defined:
  - a request with req_nonidem_i=1 is accepted only when count_o==0;
  - while a valid nonidem entry exists, req_ready_o=0 for all requests;
  - the flushed state does not lift the block; only the response does.
- Undefined: req_nonidem_i is ignored and the nonidem field is not stored. The port stays present so the interface is identical.

## Structure
- Shared package cva6_ldbuf_pkg holds:
  - ldbuf_entry_t struct;
  - size encodings LDBUF_SIZE_B/H/W;
  - the OFS_W derivation function.
- One combinational sub-module, cva6_ldbuf_extract (data, offset, size, sign → XLEN result), reused by the load unit's uncached path.
- Top-level contents: entry array, priority free-entry encoder, counter, result register.

## Test plan
- Reset, then one load: trans_id=2, offset=4, size=byte, sign=1, rsp_data=64'h0000_0080_0000_0000 → tag 0; result one cycle after response is 32'hFFFF_FF80 with trans_id=2.
- Fill two entries → req_ready_o=0 and count_o=2. Respond tag 1 and request in the same cycle → request not accepted. Next cycle ready=1, and the next accepted request gets tag 1.
- Two loads outstanding, flush_i pulse, then responses for both → no result_valid_o and count_o returns to 0. A new load after the flush produces a normal result.
- Response and flush_i in the same cycle for a clean entry → no result; the entry is freed.
- With the macro: nonidem load with one entry busy → ready=0 until that entry frees. After it is accepted, normal loads stall until its response. Without the macro: the same stimulus is accepted immediately.
- Half-word zero-extend: offset=6, size=half, sign=0, data=64'hBEEF_0000_0000_0000 → 32'h0000_BEEF.
